// File: rtl/uart_pwm_ctrl.sv
// UART-framed servo controller: parses A5/CH/HI/LO/CS frames into per-channel
// pulse widths, drives glitch-free PWM outputs and answers each frame with ACK/NAK.
module uart_pwm_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int TICK_DIV      = 27,
  parameter int PERIOD_TICKS  = 20000,
  parameter int WIDTH_BITS    = 16,
  parameter int MIN_WIDTH     = 500,
  parameter int MAX_WIDTH     = 2500,
  parameter int DEFAULT_WIDTH = 1500,
  parameter int TIMEOUT_TICKS = 5000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_ok,
  output logic              frame_err
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int P_W   = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_CH, S_HI, S_LO, S_CS, S_ACK} state_t;

  state_t                state, next_state;
  logic [DIV_W-1:0]      div_cnt;
  logic [P_W-1:0]        period_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  tick, wrap, in_frame, to_expire;
  logic [7:0]            ch_reg, hi_reg, lo_reg;
  logic [WIDTH_BITS-1:0] raw_width, clamped;
  logic [WIDTH_BITS-1:0] shadow [NUM_CH];
  logic [WIDTH_BITS-1:0] active [NUM_CH];
  logic                  frame_good, commit_ok, commit_err, timeout_err, send;

  assign tick       = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign wrap       = tick && (period_cnt == P_W'(PERIOD_TICKS - 1));
  assign in_frame   = (state == S_CH) || (state == S_HI) || (state == S_LO) || (state == S_CS);
  assign to_expire  = in_frame && tick && !rx_valid && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
  assign raw_width  = WIDTH_BITS'({hi_reg, lo_reg});
  assign frame_good = (rx_data == (ch_reg ^ hi_reg ^ lo_reg)) && (int'(ch_reg) < NUM_CH);

  always_comb begin
    clamped = raw_width;
    if (raw_width < WIDTH_BITS'(MIN_WIDTH))
      clamped = WIDTH_BITS'(MIN_WIDTH);
    else if (raw_width > WIDTH_BITS'(MAX_WIDTH))
      clamped = WIDTH_BITS'(MAX_WIDTH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Payload states advance on any byte; a byte arriving on the expiry tick wins.
  always_comb begin
    next_state  = state;
    commit_ok   = 1'b0;
    commit_err  = 1'b0;
    timeout_err = 1'b0;
    send        = 1'b0;
    case (state)
      S_IDLE: if (rx_valid && rx_data == 8'hA5) next_state = S_CH;
      S_CH, S_HI, S_LO: begin
        if (rx_valid)
          next_state = state_t'(state + 3'd1);
        else if (to_expire) begin
          next_state  = S_IDLE;
          timeout_err = 1'b1;
        end
      end
      S_CS: begin
        if (rx_valid) begin
          next_state = S_ACK;
          commit_ok  = frame_good;
          commit_err = !frame_good;
        end else if (to_expire) begin
          next_state  = S_IDLE;
          timeout_err = 1'b1;
        end
      end
      S_ACK: begin
        if (!tx_busy) begin
          send       = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ch_reg    <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      to_cnt    <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      tx_en     <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      if (rx_valid && state == S_CH) ch_reg <= rx_data;
      if (rx_valid && state == S_HI) hi_reg <= rx_data;
      if (rx_valid && state == S_LO) lo_reg <= rx_data;
      if (!in_frame || rx_valid)
        to_cnt <= '0;
      else if (tick)
        to_cnt <= to_cnt + 1'b1;
      frame_ok  <= commit_ok;
      frame_err <= commit_err || timeout_err;
      tx_en     <= send;
      if (commit_ok)
        tx_data <= 8'h06;
      else if (commit_err)
        tx_data <= 8'h15;
    end
  end

  // Active widths only change at the period wrap, so pulses are never cut short.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt    <= '0;
      period_cnt <= '0;
      pwm_out    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= WIDTH_BITS'(DEFAULT_WIDTH);
        active[i] <= WIDTH_BITS'(DEFAULT_WIDTH);
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (wrap)
        period_cnt <= '0;
      else if (tick)
        period_cnt <= period_cnt + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (commit_ok && ch_reg == 8'(i))
          shadow[i] <= clamped;
        if (wrap)
          active[i] <= shadow[i];
        pwm_out[i] <= (32'(period_cnt) < 32'(active[i]));
      end
    end
  end

endmodule
